// File: rtl/ws2812_input_decoder.sv
// ws2812_input_decoder: WS2812 single-wire receiver. Classifies high pulses by width into bits, packs MSB-first bytes, reports the reset gap as frame_end.
// Ports: clk, rst (sync, active-high), din (async line) -> data_out[7:0], data_valid, frame_end, in_frame, error.
module ws2812_input_decoder #(
  parameter int INPUT_CLOCK = 12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_end,
  output logic       in_frame,
  output logic       error
);
  localparam int GLITCH = $rtoi(150e-9 * INPUT_CLOCK);
  localparam int THRESH = $rtoi(575e-9 * INPUT_CLOCK);
  localparam int MAXHIGH = $rtoi(2e-6 * INPUT_CLOCK);
  localparam int RESET_DETECT = $rtoi(50e-6 * INPUT_CLOCK);
  localparam int HW = $clog2(MAXHIGH + 2);
  localparam int LW = $clog2(RESET_DETECT + 1);
  localparam logic [HW-1:0] H_GLITCH = HW'(GLITCH);
  localparam logic [HW-1:0] H_THRESH = HW'(THRESH);
  localparam logic [HW-1:0] H_MAX = HW'(MAXHIGH);
  localparam logic [HW-1:0] H_SAT = HW'(MAXHIGH + 1);
  localparam logic [LW-1:0] L_GAP = LW'(RESET_DETECT);
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;
  state_t state;
  logic s1, s, sp;
  logic [HW-1:0] h;
  logic [LW-1:0] l;
  logic [2:0] bit_cnt;
  logic [6:0] sh;
  logic rise, fall, bit_v;
  assign rise = s & ~sp;
  assign fall = ~s & sp;
  // h and l are registered run lengths of s, so on the falling-edge cycle h holds the full pulse width
  assign bit_v = h >= H_THRESH;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s <= 1'b0;
      sp <= 1'b0;
      h <= '0;
      l <= '0;
      bit_cnt <= '0;
      sh <= '0;
      state <= SYNC;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_end <= 1'b0;
      in_frame <= 1'b0;
      error <= 1'b0;
    end else begin
      s1 <= din;
      s <= s1;
      sp <= s;
      h <= s ? (h == H_SAT ? h : h + 1'b1) : '0;
      l <= s ? '0 : (l == L_GAP ? l : l + 1'b1);
      data_valid <= 1'b0;
      frame_end <= 1'b0;
      error <= 1'b0;
      case (state)
        SYNC: if (l == L_GAP) state <= IDLE;
        IDLE: if (rise) state <= HIGH;
        HIGH:
          if (h > H_MAX || (fall && h <= H_GLITCH)) begin
            error <= 1'b1;
            bit_cnt <= '0;
            in_frame <= 1'b0;
            state <= SYNC;
          end else if (fall) begin
            sh <= {sh[5:0], bit_v};
            bit_cnt <= bit_cnt + 1'b1;
            in_frame <= 1'b1;
            state <= LOW;
            if (bit_cnt == 3'd7) begin
              data_out <= {sh, bit_v};
              data_valid <= 1'b1;
            end
          end
        LOW:
          if (rise) state <= HIGH;
          else if (l == L_GAP) begin
            frame_end <= 1'b1;
            error <= bit_cnt != 3'd0;
            bit_cnt <= '0;
            in_frame <= 1'b0;
            state <= IDLE;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_input_decoder.sv
// tb_ws2812_input_decoder: self-checking bench; byte scoreboard plus table-driven pulse-width sweep.
module tb_ws2812_input_decoder;
  logic clk = 1'b0, rst = 1'b1, din = 1'b0;
  logic [7:0] data_out;
  logic data_valid, frame_end, in_frame, error;
  int n_checks = 0, n_fail = 0, cyc = 0;
  int dv_n = 0, fe_n = 0, err_n = 0, dv_cyc = -1, fe_cyc = -1, err_cyc = -1, last_fall = 0;
  logic [7:0] sb[$];
  typedef struct {int hw; logic [7:0] exp; bit ok;} vec_t;
  vec_t vt[6];

  ws2812_input_decoder #(.INPUT_CLOCK(12_000_000)) dut (
    .clk(clk), .rst(rst), .din(din), .data_out(data_out), .data_valid(data_valid),
    .frame_end(frame_end), .in_frame(in_frame), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (data_valid) begin
      dv_n++;
      dv_cyc = cyc;
      if (sb.size() == 0) chk("dv_unexpected", {24'd0, data_out}, 32'hFFFF_FFFF);
      else chk("dv_byte", {24'd0, data_out}, {24'd0, sb.pop_front()});
    end
    if (frame_end) begin fe_n++; fe_cyc = cyc; end
    if (error) begin err_n++; err_cyc = cyc; end
  end

  task automatic low(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic bitw(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    last_fall = cyc;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) bitw(9, 8);
    else bitw(4, 13);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_it);
    if (expect_it) sb.push_back(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
    chk({tag, "_dv"}, {31'd0, data_valid}, 32'd0);
    chk({tag, "_fe"}, {31'd0, frame_end}, 32'd0);
    chk({tag, "_in_frame"}, {31'd0, in_frame}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    int fe0, err0, dv0;
    vt[0] = '{5, 8'h00, 1'b1};
    vt[1] = '{6, 8'hFF, 1'b1};
    vt[2] = '{24, 8'hFF, 1'b1};
    vt[3] = '{25, 8'h00, 1'b0};
    vt[4] = '{2, 8'h00, 1'b1};
    vt[5] = '{9, 8'hFF, 1'b1};
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    // basic byte with latency and gap timing
    low(600);
    fe0 = fe_n; err0 = err_n;
    send_byte(8'hA5, 1'b1);
    chk("t1_in_frame", {31'd0, in_frame}, 32'd1);
    chk("t1_dv_latency", dv_cyc, last_fall + 3);
    low(700);
    chk("t1_fe_count", fe_n - fe0, 32'd1);
    chk("t1_fe_latency", fe_cyc, last_fall + 603);
    chk("t1_err_count", err_n - err0, 32'd0);
    chk("t1_in_frame_end", {31'd0, in_frame}, 32'd0);
    // back-to-back bytes in one frame
    low(600);
    fe0 = fe_n; dv0 = dv_n;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    low(700);
    chk("t2_dv_count", dv_n - dv0, 32'd3);
    chk("t2_fe_count", fe_n - fe0, 32'd1);
    // pulse width sweep, one fresh frame per entry
    foreach (vt[k]) begin
      low(700);
      fe0 = fe_n; err0 = err_n; dv0 = dv_n;
      if (vt[k].ok) sb.push_back(vt[k].exp);
      for (int i = 0; i < 8; i++) bitw(vt[k].hw, 10);
      low(700);
      chk($sformatf("t3_h%0d_dv", vt[k].hw), dv_n - dv0, vt[k].ok ? 32'd1 : 32'd0);
      chk($sformatf("t3_h%0d_err", vt[k].hw), err_n - err0, vt[k].ok ? 32'd0 : 32'd1);
      chk($sformatf("t3_h%0d_fe", vt[k].hw), fe_n - fe0, vt[k].ok ? 32'd1 : 32'd0);
    end
    // glitch mid-byte, then resync and decode
    err0 = err_n; dv0 = dv_n;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bitw(1, 10);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("t4_err", err_n - err0, 32'd1);
    chk("t4_no_dv", dv_n - dv0, 32'd0);
    chk("t4_in_frame", {31'd0, in_frame}, 32'd0);
    low(610);
    send_byte(8'h5A, 1'b1);
    low(700);
    chk("t4_dv_after", dv_n - dv0, 32'd1);
    // partial byte at gap
    fe0 = fe_n; err0 = err_n; dv0 = dv_n;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    low(700);
    chk("t5_fe", fe_n - fe0, 32'd1);
    chk("t5_err", err_n - err0, 32'd1);
    chk("t5_same_cycle", err_cyc, fe_cyc);
    chk("t5_no_dv", dv_n - dv0, 32'd0);
    send_byte(8'h81, 1'b1);
    low(700);
    chk("t5_next_dv", dv_n - dv0, 32'd1);
    // bits straight after reset are ignored; reset mid-byte clears everything
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dv0 = dv_n; fe0 = fe_n;
    send_byte(8'hFF, 1'b0);
    low(100);
    chk("t6_no_dv", dv_n - dv0, 32'd0);
    chk("t6_no_fe", fe_n - fe0, 32'd0);
    low(600);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("t6_in_frame_pre", {31'd0, in_frame}, 32'd1);
    din = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("t6_midrst");
    din = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    low(600);
    send_byte(8'hC3, 1'b1);
    low(700);
    chk("t6_dv_after", dv_n - dv0, 32'd1);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ws2812_input_decoder.md
# ws2812_input_decoder

Single-wire WS2812 stream decoder: samples an asynchronous WS2812 data line, classifies each high pulse as a 0 or 1 bit by its width, and assembles bits MSB-first into bytes. Each completed byte is presented with a one-cycle strobe, and the ≥50 µs low reset gap is reported as end of frame. Serves as the receive-side counterpart of the ws2812 output shifter, for loopback test, LED-chain sniffing and daisy-chain input.

## Interface
- INPUT_CLOCK, 12_000_000: clk frequency in Hz; must be ≥12 MHz.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- din  in  1  WS2812 line, asynchronous to clk.
- data_out  out  8  last decoded byte; held until the next byte completes.
- data_valid  out  1  one-cycle strobe; data_out is new this cycle.
- frame_end  out  1  one-cycle strobe; reset gap detected after ≥1 received bit.
- in_frame  out  1  level; high from the first accepted bit until frame_end or error.
- error  out  1  one-cycle strobe; protocol violation or partial byte discarded.

## Operation
- Derived constants, in clk cycles:
  - GLITCH = $rtoi(150e-9*INPUT_CLOCK)
  - THRESH = $rtoi(575e-9*INPUT_CLOCK)
  - MAXHIGH = $rtoi(2e-6*INPUT_CLOCK)
  - RESET_DETECT = $rtoi(50e-6*INPUT_CLOCK)
  - At 12 MHz these are 1 / 6 / 24 / 600.
- din passes through a 2-flop synchronizer, giving s. All counting and edge detection use s.
- h = number of consecutive cycles s is high, with the first high cycle counted as 1.
- l = number of consecutive cycles s is low, with the first low cycle counted as 1. The l counter saturates at RESET_DETECT.
- States:
  - SYNC (reset state): wait for l == RESET_DETECT, then go to IDLE. No outputs fire; rising edges restart l.
  - IDLE: on a rising edge, go to HIGH.
  - HIGH: count h.
    - If h > MAXHIGH: error, go to SYNC.
    - On a falling edge with h ≤ GLITCH: error, go to SYNC.
    - On a falling edge otherwise: the bit is (h ≥ THRESH). Shift it in and increment bit_cnt (3 bits). On the 8th bit, load data_out, pulse data_valid and reset bit_cnt to 0. Set in_frame. Go to LOW.
  - LOW: count l.
    - On a rising edge: go to HIGH. Low width is not checked below the gap threshold.
    - If l == RESET_DETECT: pulse frame_end; if bit_cnt ≠ 0, also pulse error in the same cycle and discard the partial bits. Clear in_frame and bit_cnt, go to IDLE.
- On any error: discard the partial byte, clear bit_cnt and in_frame, go to SYNC. The next frame is accepted only after a full reset gap.
- A gap in IDLE with no bits received produces no frame_end.
- data_valid and frame_end never coincide, because they are caused by different edges.

## Timing
- Reset values:
  - data_out = 0x00
  - data_valid, frame_end, error, in_frame = 0
  - synchronizer flops = 0
  - bit_cnt = 0
  - state = SYNC
- rst asserted mid-byte or mid-gap abandons all progress at the next clk edge, with identical reset values.
- Latency: data_valid rises 3 clk edges after the first clk edge that samples din low at the 8th bit's falling edge (2 synchronizer stages plus 1 registered output).
- frame_end/error on a gap rise 1 cycle after l reaches RESET_DETECT, i.e. RESET_DETECT+3 edges after the last pin falling edge.
- All strobes last exactly 1 cycle. There is no back-pressure; the consumer must accept data_valid when it is presented.
- Minimum spacing between data_valid pulses is 8 bit periods. Back-to-back bytes need no gap.

## Test plan
All scenarios use INPUT_CLOCK = 12 MHz. Bit "0" = 4 cycles high / 13 cycles low; bit "1" = 9 cycles high / 8 cycles low.

1. rst, then 600 low, then byte 0xA5, then 700 low -> one data_valid with data_out=0xA5 3 cycles after the 8th falling edge; in_frame high during the byte; one frame_end 603 cycles after the last falling edge; error never asserts.
2. 600 low, then 0x00, 0xFF, 0x3C back-to-back, then 700 low -> three data_valid pulses with 0x00, 0xFF, 0x3C in order; exactly one frame_end.
3. Threshold sweep, each in a fresh frame of 8 equal bits:
   - h=5 ×8 -> 0x00
   - h=6 ×8 -> 0xFF
   - h=24 -> accepted
   - h=25 -> error at the 25th high cycle, no data_valid
4. 1-cycle high glitch mid-byte -> error; following bits ignored (no data_valid) until 600 low; the next byte 0x5A then decodes correctly.
5. 5 bits, then 700 low -> frame_end and error pulse in the same cycle; no data_valid; the next byte decodes from bit 0.
6. Bits sent immediately after rst with no gap -> ignored. rst asserted mid-byte -> all outputs return to reset values; after 600 low, 0xC3 decodes.
